// File: rtl/mc_core.sv
`default_nettype none
// ============================================================================
// Module   : mc_core
// Brief    : Multi-cycle RV32I/RV32E integer core. FETCH/DECODE/EXECUTE/
//            WRITE_BACK sequencer with valid/ack instruction bus, precise
//            halt-on-trap and a writeback observation port.
//            Optional build macro MC_CORE_COUNTERS_EN adds cycle/instret
//            counters readable through CSRRS rd, csr, x0.
// Revision : 1.0 - initial release
// ============================================================================
module mc_core #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              retire,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [31:0]       wb_data,
  output logic [31:0]       pc_o,
  output logic              halted,
  output logic [1:0]        trap_cause
);

  localparam int         RIDX_W  = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_WB      = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  trap_q, trap_d;
  logic [31:0] ir_q, rs1v_q, rs2v_q, npc_q, wb_data_q;
  logic [4:0]  wb_addr_q;
  logic        wr_q;
  logic        req_en_q;   // keeps imem_req low for the cycle after reset
  logic [31:0] rf_q [NREGS];

  // Instruction fields and immediates
  logic [6:0]  opc_w, f7_w;
  logic [4:0]  rd_w, rs1_w, rs2_w;
  logic [2:0]  f3_w;
  logic [31:0] imm_i_w, imm_b_w, imm_j_w, imm_u_w;
  assign opc_w   = ir_q[6:0];
  assign rd_w    = ir_q[11:7];
  assign f3_w    = ir_q[14:12];
  assign rs1_w   = ir_q[19:15];
  assign rs2_w   = ir_q[24:20];
  assign f7_w    = ir_q[31:25];
  assign imm_i_w = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_b_w = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j_w = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign imm_u_w = {ir_q[31:12], 12'b0};

  logic        csr_ok_w;
  logic [31:0] csr_val_w;

`ifdef MC_CORE_COUNTERS_EN
  logic [63:0] cycle_q, instret_q;

  // Free-running cycle counter (stops in HALT) and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else begin
      if (state_q != S_HALT) cycle_q <= cycle_q + 64'd1;
      if (retire)            instret_q <= instret_q + 64'd1;
    end
  end

  // Read-only counter CSRs; only CSRRS with rs1=x0 is a legal access
  always_comb begin
    csr_val_w = 32'd0;
    csr_ok_w  = (opc_w == OPC_SYSTEM) && (f3_w == 3'b010) && (rs1_w == 5'd0);
    case (ir_q[31:20])
      12'hC00, 12'hC01: csr_val_w = cycle_q[31:0];
      12'hC02:          csr_val_w = instret_q[31:0];
      12'hC80, 12'hC81: csr_val_w = cycle_q[63:32];
      12'hC82:          csr_val_w = instret_q[63:32];
      default:          csr_ok_w  = 1'b0;
    endcase
  end
`else
  assign csr_ok_w  = 1'b0;
  assign csr_val_w = 32'd0;
`endif

  // Legality and register-usage decode of the held instruction
  logic legal_w, use_rd_w, use_rs1_w, use_rs2_w, illegal_w;
  always_comb begin
    legal_w   = 1'b0;
    use_rd_w  = 1'b0;
    use_rs1_w = 1'b0;
    use_rs2_w = 1'b0;
    case (opc_w)
      OPC_OP: begin
        legal_w = (f7_w == 7'h00) || (f7_w == 7'h20 && (f3_w == 3'd0 || f3_w == 3'd5));
        {use_rd_w, use_rs1_w, use_rs2_w} = 3'b111;
      end
      OPC_OPIMM: begin
        legal_w = (f3_w == 3'd1) ? (f7_w == 7'h00) :
                  (f3_w == 3'd5) ? (f7_w == 7'h00 || f7_w == 7'h20) : 1'b1;
        {use_rd_w, use_rs1_w} = 2'b11;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        legal_w  = 1'b1;
        use_rd_w = 1'b1;
      end
      OPC_JALR: begin
        legal_w = (f3_w == 3'd0);
        {use_rd_w, use_rs1_w} = 2'b11;
      end
      OPC_BRANCH: begin
        legal_w = (f3_w != 3'd2) && (f3_w != 3'd3);
        {use_rs1_w, use_rs2_w} = 2'b11;
      end
      OPC_FENCE:  legal_w = (f3_w == 3'd0);
      OPC_SYSTEM: begin
        legal_w  = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073) || csr_ok_w;
        use_rd_w = csr_ok_w;
      end
      default: legal_w = 1'b0;
    endcase
    illegal_w = !legal_w
              || (use_rd_w  && ({1'b0, rd_w}  >= NREGS_W))
              || (use_rs1_w && ({1'b0, rs1_w} >= NREGS_W))
              || (use_rs2_w && ({1'b0, rs2_w} >= NREGS_W));
  end

  // Register-file read ports (x0 reads as zero)
  logic [31:0] rf_rs1_w, rf_rs2_w;
  assign rf_rs1_w = (rs1_w == 5'd0) ? 32'd0 : rf_q[rs1_w[RIDX_W-1:0]];
  assign rf_rs2_w = (rs2_w == 5'd0) ? 32'd0 : rf_q[rs2_w[RIDX_W-1:0]];

  // ALU, branch resolution, next PC and writeback value
  logic [31:0] opb_w, alu_w, target_w, res_w;
  logic        taken_w, wr_w, ecall_w, misalign_w;
  always_comb begin
    opb_w = (opc_w == OPC_OP) ? rs2v_q : imm_i_w;
    case (f3_w)
      3'd0:    alu_w = (opc_w == OPC_OP && f7_w[5]) ? rs1v_q - opb_w : rs1v_q + opb_w;
      3'd1:    alu_w = rs1v_q << opb_w[4:0];
      3'd2:    alu_w = {31'd0, $signed(rs1v_q) < $signed(opb_w)};
      3'd3:    alu_w = {31'd0, rs1v_q < opb_w};
      3'd4:    alu_w = rs1v_q ^ opb_w;
      3'd5:    alu_w = ((opc_w == OPC_OP) ? f7_w[5] : imm_i_w[10])
                     ? 32'($signed(rs1v_q) >>> opb_w[4:0]) : rs1v_q >> opb_w[4:0];
      3'd6:    alu_w = rs1v_q | opb_w;
      default: alu_w = rs1v_q & opb_w;
    endcase
    taken_w  = 1'b0;
    target_w = pc_q + imm_b_w;
    res_w    = alu_w;
    wr_w     = (rd_w != 5'd0);
    case (opc_w)
      OPC_BRANCH: begin
        wr_w = 1'b0;
        case (f3_w)
          3'd0:    taken_w = (rs1v_q == rs2v_q);
          3'd1:    taken_w = (rs1v_q != rs2v_q);
          3'd4:    taken_w = ($signed(rs1v_q) <  $signed(rs2v_q));
          3'd5:    taken_w = ($signed(rs1v_q) >= $signed(rs2v_q));
          3'd6:    taken_w = (rs1v_q <  rs2v_q);
          default: taken_w = (rs1v_q >= rs2v_q);
        endcase
      end
      OPC_JAL:   begin taken_w = 1'b1; target_w = pc_q + imm_j_w; res_w = pc_q + 32'd4; end
      OPC_JALR:  begin taken_w = 1'b1; target_w = (rs1v_q + imm_i_w) & ~32'd1; res_w = pc_q + 32'd4; end
      OPC_LUI:   res_w = imm_u_w;
      OPC_AUIPC: res_w = pc_q + imm_u_w;
      OPC_SYSTEM: begin res_w = csr_val_w; wr_w = csr_ok_w && (rd_w != 5'd0); end
      OPC_OP, OPC_OPIMM: res_w = alu_w;
      default:   wr_w = 1'b0;
    endcase
    ecall_w    = (opc_w == OPC_SYSTEM) && (f3_w == 3'd0);
    misalign_w = taken_w && target_w[1];
  end

  // Next-state logic of the instruction sequencer
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    trap_d  = trap_q;
    case (state_q)
      S_FETCH:  if (imem_req && imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (illegal_w) begin state_d = S_HALT; trap_d = 2'd1; end
        else                 state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (ecall_w)         begin state_d = S_HALT; trap_d = 2'd3; end
        else if (misalign_w) begin state_d = S_HALT; trap_d = 2'd2; end
        else                 state_d = S_WB;
      end
      S_WB:     begin state_d = S_FETCH; pc_d = npc_q; end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // State, PC and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      trap_q    <= 2'd0;
      req_en_q  <= 1'b0;
      ir_q      <= 32'd0;
      rs1v_q    <= 32'd0;
      rs2v_q    <= 32'd0;
      npc_q     <= 32'd0;
      wr_q      <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      trap_q   <= trap_d;
      req_en_q <= 1'b1;
      if (state_q == S_FETCH && imem_req && imem_ack) ir_q <= imem_rdata;
      if (state_q == S_DECODE) begin
        rs1v_q <= rf_rs1_w;
        rs2v_q <= rf_rs2_w;
      end
      if (state_q == S_EXECUTE) begin
        npc_q     <= taken_w ? target_w : pc_q + 32'd4;
        wr_q      <= wr_w;
        wb_addr_q <= rd_w;
        wb_data_q <= res_w;
      end
    end
  end

  // Register-file write port, used only in WRITE_BACK
  always_ff @(posedge clk) begin
    if (state_q == S_WB && wr_q) rf_q[wb_addr_q[RIDX_W-1:0]] <= wb_data_q;
  end

  assign imem_req   = (state_q == S_FETCH) && req_en_q;
  assign imem_addr  = pc_q[ADDR_W-1:0];
  assign retire     = (state_q == S_WB);
  assign wb_en      = retire && wr_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign pc_o       = pc_q;
  assign halted     = (state_q == S_HALT);
  assign trap_cause = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_core
// Brief    : Directed self-checking bench for mc_core (RV32E build). Expected
//            retire events are queued when a program is loaded and compared
//            against the retire stream observed from the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        retire, wb_en, halted;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, pc_o;
  logic [1:0]  trap_cause;

  mc_core #(.ADDR_W(32), .RESET_PC(32'h0), .NREGS(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .retire(retire), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_o(pc_o), .halted(halted), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    int unsigned cyc;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] ef_q[$];
  logic [31:0] mem [64];
  logic [31:0] delay_addr   = 32'hFFFF_FFFF;
  int          delay_cycles = 0;
  int          wait_cnt     = 0;
  logic [31:0] held_addr    = 32'd0;
  int unsigned cyc          = 0;
  int          n_cmp        = 0;
  int          n_err        = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  always @(posedge clk) cyc++;

  // Instruction memory with programmable wait states on one address
  always @(negedge clk) begin
    if (rst || !imem_req) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      if (wait_cnt == 0) held_addr = imem_addr;
      else               check("addr_stable", imem_addr, held_addr);
      if (imem_addr == delay_addr && wait_cnt < delay_cycles) begin
        imem_ack = 1'b0;
        wait_cnt++;
      end else begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr[7:2]];
        fetch_q.push_back(imem_addr);
        wait_cnt   = 0;
        if (imem_addr == delay_addr) delay_addr = 32'hFFFF_FFFF;
      end
    end
  end

  // Retire-stream monitor
  always @(negedge clk) begin
    if (retire === 1'b1) obs_q.push_back('{pc_o, wb_en, wb_addr, wb_data, cyc});
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    obs_q.delete();
    fetch_q.delete();
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic en, input logic [4:0] a,
                          input logic [31:0] d);
    exp_q.push_back('{pc, en, a, d, 0});
  endtask

  task automatic wait_halt(input string tag, input logic [1:0] cause, input logic [31:0] pc);
    for (int i = 0; i < 600 && halted !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    check({tag, "_cause"}, {30'd0, trap_cause}, {30'd0, cause});
    check({tag, "_pc"}, pc_o, pc);
  endtask

  task automatic drain(input string tag);
    ev_t o, e;
    check({tag, "_nretire"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_pc"}, o.pc, e.pc);
      check({tag, "_wben"}, {31'd0, o.en}, {31'd0, e.en});
      if (e.en) begin
        check({tag, "_wbaddr"}, {27'd0, o.a}, {27'd0, e.a});
        check({tag, "_wbdata"}, o.d, e.d);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_fetch(input string tag);
    check({tag, "_nfetch"}, 32'(fetch_q.size()), 32'(ef_q.size()));
    for (int i = 0; i < ef_q.size() && i < fetch_q.size(); i++)
      check({tag, "_fetch"}, fetch_q[i], ef_q[i]);
    ef_q.delete();
    fetch_q.delete();
  endtask

  task automatic spacing(input string tag, input int unsigned exp);
    if (obs_q.size() >= 2) check(tag, obs_q[1].cyc - obs_q[0].cyc, exp);
    else                   check(tag, 32'(obs_q.size()), 32'd2);
  endtask

  initial begin
    // ---- reset state ----
    clear_mem();
    do_reset();
    check("rst_req",     {31'd0, imem_req}, 32'd0);
    check("rst_retire",  {31'd0, retire}, 32'd0);
    check("rst_wben",    {31'd0, wb_en}, 32'd0);
    check("rst_halted",  {31'd0, halted}, 32'd0);
    check("rst_cause",   {30'd0, trap_cause}, 32'd0);
    check("rst_wbaddr",  {27'd0, wb_addr}, 32'd0);
    check("rst_wbdata",  wb_data, 32'd0);
    check("rst_pc",      pc_o, 32'd0);

    // ---- two ADDIs, zero-wait ----
    mem[0] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5);
    mem[1] = enc_i(7'h13, 3'd0, 5'd2, 5'd1, 12'hFF9);
    mem[2] = ECALL;
    push_exp(32'h0, 1'b1, 5'd1, 32'd5);
    push_exp(32'h4, 1'b1, 5'd2, 32'hFFFF_FFFE);
    ef_q = '{32'h0, 32'h4, 32'h8};
    do_reset();
    wait_halt("t1", 2'd3, 32'h8);
    spacing("t1_spacing", 4);
    drain("t1");
    check_fetch("t1");

    // ---- same program, 3 wait states on the second fetch ----
    push_exp(32'h0, 1'b1, 5'd1, 32'd5);
    push_exp(32'h4, 1'b1, 5'd2, 32'hFFFF_FFFE);
    ef_q = '{32'h0, 32'h4, 32'h8};
    delay_addr = 32'h4; delay_cycles = 3;
    do_reset();
    wait_halt("t2", 2'd3, 32'h8);
    spacing("t2_spacing", 7);
    drain("t2");
    check_fetch("t2");

    // ---- BLT taken, BLTU not taken ----
    clear_mem();
    mem[0] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5);
    mem[1] = enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'hFFE);
    mem[2] = enc_b(3'd4, 5'd2, 5'd1, 13'd8);
    mem[4] = enc_b(3'd6, 5'd2, 5'd1, 13'd8);
    mem[5] = ECALL;
    push_exp(32'h0,  1'b1, 5'd1, 32'd5);
    push_exp(32'h4,  1'b1, 5'd2, 32'hFFFF_FFFE);
    push_exp(32'h8,  1'b0, 5'd0, 32'd0);
    push_exp(32'h10, 1'b0, 5'd0, 32'd0);
    ef_q = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h14};
    do_reset();
    wait_halt("t3", 2'd3, 32'h14);
    drain("t3");
    check_fetch("t3");

    // ---- ADDI x0, LUI, JAL +8, AUIPC ----
    clear_mem();
    mem[0] = enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd1);
    mem[1] = enc_u(7'h37, 5'd3, 20'h12345);
    mem[2] = NOP;
    mem[3] = NOP;
    mem[4] = enc_j(5'd1, 21'd8);
    mem[6] = NOP;
    mem[7] = NOP;
    mem[8] = enc_u(7'h17, 5'd4, 20'h1);
    mem[9] = ECALL;
    push_exp(32'h0,  1'b0, 5'd0, 32'd0);
    push_exp(32'h4,  1'b1, 5'd3, 32'h1234_5000);
    push_exp(32'h8,  1'b0, 5'd0, 32'd0);
    push_exp(32'hC,  1'b0, 5'd0, 32'd0);
    push_exp(32'h10, 1'b1, 5'd1, 32'h14);
    push_exp(32'h18, 1'b0, 5'd0, 32'd0);
    push_exp(32'h1C, 1'b0, 5'd0, 32'd0);
    push_exp(32'h20, 1'b1, 5'd4, 32'h1020);
    ef_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h1C, 32'h20, 32'h24};
    do_reset();
    wait_halt("t4", 2'd3, 32'h24);
    drain("t4");
    check_fetch("t4");

    // ---- JAL +6 at 0x10: misaligned target ----
    clear_mem();
    for (int i = 0; i < 4; i++) begin
      mem[i] = NOP;
      push_exp(32'(i * 4), 1'b0, 5'd0, 32'd0);
    end
    mem[4] = enc_j(5'd1, 21'd6);
    do_reset();
    wait_halt("t5", 2'd2, 32'h10);
    drain("t5");

    // ---- ALU coverage: shifts, SUB, compares, logic ----
    clear_mem();
    mem[0]  = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'hFF0);
    mem[1]  = enc_i(7'h13, 3'd5, 5'd2, 5'd1, 12'h402);
    mem[2]  = enc_i(7'h13, 3'd5, 5'd3, 5'd1, 12'd28);
    mem[3]  = enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd4);
    mem[4]  = enc_r(7'h00, 5'd3, 5'd1, 3'd2, 5'd5);
    mem[5]  = enc_r(7'h00, 5'd3, 5'd1, 3'd3, 5'd6);
    mem[6]  = enc_i(7'h13, 3'd4, 5'd7, 5'd1, 12'h0FF);
    mem[7]  = enc_r(7'h00, 5'd3, 5'd3, 3'd1, 5'd8);
    mem[8]  = enc_r(7'h00, 5'd7, 5'd1, 3'd7, 5'd9);
    mem[9]  = enc_r(7'h20, 5'd3, 5'd1, 3'd5, 5'd10);
    mem[10] = ECALL;
    push_exp(32'h00, 1'b1, 5'd1,  32'hFFFF_FFF0);
    push_exp(32'h04, 1'b1, 5'd2,  32'hFFFF_FFFC);
    push_exp(32'h08, 1'b1, 5'd3,  32'h0000_000F);
    push_exp(32'h0C, 1'b1, 5'd4,  32'h0000_001F);
    push_exp(32'h10, 1'b1, 5'd5,  32'h0000_0001);
    push_exp(32'h14, 1'b1, 5'd6,  32'h0000_0000);
    push_exp(32'h18, 1'b1, 5'd7,  32'hFFFF_FF0F);
    push_exp(32'h1C, 1'b1, 5'd8,  32'h0007_8000);
    push_exp(32'h20, 1'b1, 5'd9,  32'hFFFF_FF00);
    push_exp(32'h24, 1'b1, 5'd10, 32'hFFFF_FFFF);
    do_reset();
    wait_halt("t6", 2'd3, 32'h28);
    drain("t6");

    // ---- CSRRS x5, instret, x0 as third instruction ----
    clear_mem();
    mem[0] = NOP;
    mem[1] = NOP;
    mem[2] = {12'hC02, 5'd0, 3'b010, 5'd5, 7'h73};
    mem[3] = ECALL;
    push_exp(32'h0, 1'b0, 5'd0, 32'd0);
    push_exp(32'h4, 1'b0, 5'd0, 32'd0);
`ifdef MC_CORE_COUNTERS_EN
    push_exp(32'h8, 1'b1, 5'd5, 32'd2);
    do_reset();
    wait_halt("t7", 2'd3, 32'hC);
`else
    do_reset();
    wait_halt("t7", 2'd1, 32'h8);
`endif
    drain("t7");

    // ---- reset while a fetch waits, then RV32E register-index trap ----
    clear_mem();
    mem[0] = enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5);
    mem[1] = ECALL;
    push_exp(32'h0, 1'b1, 5'd1, 32'd5);
    delay_addr = 32'h4; delay_cycles = 1000;
    do_reset();
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    drain("t8a");
    check("t8_req_wait",  {31'd0, imem_req}, 32'd1);
    check("t8_addr_wait", imem_addr, 32'h4);
    @(posedge clk); #1 rst = 1'b1;
    delay_addr = 32'hFFFF_FFFF;
    mem[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd17);
    @(posedge clk); #1 rst = 1'b0;
    check("t8_req_dropped", {31'd0, imem_req}, 32'd0);
    fetch_q.delete();
    obs_q.delete();
    ef_q = '{32'h0};
    wait_halt("t8", 2'd1, 32'h0);
    drain("t8b");
    check_fetch("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_core.md
Name: mc_core

Overview:
- Parametrised multi-cycle RV32I integer core; successor to the current 4-state sequencer.
- Adds:
  - valid/ack instruction-bus handshake with wait states;
  - conditional branches, LUI, AUIPC;
  - configurable reset vector and register count (RV32I or RV32E);
  - precise halt-on-trap;
  - writeback observation port for the bench.
- Sits between instruction memory and the testbench/top level. Register file, decode and ALU are internal.

Parameters:
- ADDR_W, 32, width of imem_addr in bits (byte address, upper PC bits above ADDR_W are truncated on output only).
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- NREGS, 32, architectural registers, 32 (RV32I) or 16 (RV32E).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  ADDR_W  byte address of the fetch; stable while imem_req is high.
- imem_ack  in  1  fetch accepted; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- retire  out  1  one-cycle pulse per completed instruction.
- wb_en  out  1  register write this cycle; rd is never 0.
- wb_addr  out  5  destination register.
- wb_data  out  32  value written.
- pc_o  out  32  PC of the instruction currently in flight.
- halted  out  1  core stopped; sticky until rst.
- trap_cause  out  2  0 none, 1 illegal, 2 misaligned target, 3 ECALL/EBREAK.

Behaviour:
- Reset (rst high at an edge):
  - state=FETCH, pc=RESET_PC.
  - imem_req, retire, wb_en, halted = 0; trap_cause=0; wb_addr/wb_data=0.
  - Register file contents undefined except x0=0.
  - Reset mid-fetch drops imem_req the next cycle; a late ack is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc[ADDR_W-1:0].
  - On an edge with imem_ack=1: capture imem_rdata into IR, go DECODE.
  - Otherwise stay in FETCH; no timeout.
- DECODE:
  - imem_req=0. Decode IR; read rs1/rs2.
  - Illegal encodings, or register index >= NREGS: go HALT, trap_cause=1.
- EXECUTE:
  - ALU result and next PC computed and registered.
  - Shifts use operand[4:0]. SLT/SLTU are signed/unsigned.
  - SUB/SRA are selected by funct7[5] for OP only; SRAI is selected by imm[10].
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU. Target=pc+B-imm.
  - JAL target=pc+J-imm. JALR target=(rs1+I-imm)&~1.
  - Taken target with bit1 set: go HALT, trap_cause=2, no writeback.
  - ECALL/EBREAK: go HALT, trap_cause=3.
  - FENCE: treated as NOP.
- WRITE_BACK:
  - wb_en=1 for one cycle if the instruction writes rd and rd!=0.
  - wb_data per opcode:
    - OP/OP-IMM: ALU result.
    - LUI: U-imm.
    - AUIPC: pc+U-imm.
    - JAL/JALR: pc+4.
  - retire=1 for one cycle.
  - pc updates to the taken target or pc+4 (wraps modulo 2^32). Go FETCH.
- HALT:
  - halted=1; imem_req=0.
  - pc_o holds the PC of the faulting instruction.
  - No retire, no register write. Leaves HALT only on rst.
- Latency: 4 cycles per instruction with zero-wait ack; each FETCH wait cycle adds 1.
- Register writes and reads never occur in the same cycle, so no bypass is needed.
- Loads/stores are illegal in this generation (trap_cause=1).

Optional Feature:
- Macro: MC_CORE_COUNTERS_EN.
- Defined:
  - 64-bit cycle counter, incremented every cycle while not halted; cleared on rst.
  - 64-bit instret counter, incremented on retire.
  - CSRRS with rs1=x0 reads cycle, time (alias of cycle) and instret, low and high halves, into rd:
    - low halves: 0xC00, 0xC01, 0xC02;
    - high halves: 0xC80, 0xC81, 0xC82.
  - Any other CSR access, or one with rs1!=x0, traps with cause 1.
- Undefined: every SYSTEM opcode other than ECALL/EBREAK traps with cause 1; no counter flops.

Test Plan:
- Zero-wait ack, ADDI x1,x0,5; ADDI x2,x1,-7 -> wb x1=5 then x2=0xFFFFFFFE; retire every 4 cycles; imem_addr 0, 4.
- imem_ack delayed 3 cycles on the second fetch -> imem_req and imem_addr=4 held stable; retire spacing 7 cycles; no duplicate retire.
- BLT x2,x1,+8 with x2=-2, x1=5 -> taken; next imem_addr=pc+8. Same values with BLTU -> not taken; next imem_addr=pc+4.
- JAL x1,+6 at pc=0x10 -> halted=1, trap_cause=2, pc_o=0x10, no wb_en. Same with +8 -> x1=0x14, fetch 0x18.
- ADDI x0,x0,1 then LUI x3,0x12345; AUIPC x4,1 at pc=0x20 -> no wb for x0; x3=0x12345000; x4=0x1020.
- rst asserted for one cycle while imem_req waits; NREGS=16 with ADD x17,... after restart -> restart fetch at RESET_PC; the ADD halts with trap_cause=1.
- (MC_CORE_COUNTERS_EN) CSRRS x5,0xC02,x0 as the third instruction -> x5=2.
